// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the debug loader (dbg),
// the core data port (data) and the core instruction port (instr). One
// transaction is in flight at a time. Read data is routed back to its owner.
// A starvation counter promotes instr to top priority after a bounded wait.
module mem_arbiter #(
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   // debug / loader port
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   input  logic [3:0]  dbg_strb,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   // core data port
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_strb,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   // core instruction port (read-only)
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_gnt,
   output logic        instr_rvalid,
   output logic [31:0] instr_rdata,
   // memory macro side
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_strb,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   typedef enum logic [1:0] {
      OWN_DBG,
      OWN_DATA,
      OWN_INSTR
   } owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              we_q, we_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        strb_q, strb_d;
   logic [31:0]       dbg_rdata_q, dbg_rdata_d;
   logic [31:0]       data_rdata_q, data_rdata_d;
   logic [31:0]       instr_rdata_q, instr_rdata_d;
   logic              boost;

   // instr has waited long enough to jump ahead of dbg and data
   assign boost = (starve_q == STV_MAX);

   // fixed-priority grant (dbg > data > instr), boosted instr first; only in IDLE
   always_comb begin
      dbg_gnt   = 1'b0;
      data_gnt  = 1'b0;
      instr_gnt = 1'b0;
      if (state_q == ST_IDLE) begin
         if (boost && instr_req) begin
            instr_gnt = 1'b1;
         end else if (dbg_req) begin
            dbg_gnt = 1'b1;
         end else if (data_req) begin
            data_gnt = 1'b1;
         end else if (instr_req) begin
            instr_gnt = 1'b1;
         end
      end
   end

   // transaction sequencing: latch command on grant, issue, wait, respond
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      we_d          = we_q;
      lat_d         = lat_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      strb_d        = strb_q;
      dbg_rdata_d   = dbg_rdata_q;
      data_rdata_d  = data_rdata_q;
      instr_rdata_d = instr_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (dbg_gnt) begin
               owner_d = OWN_DBG;
               we_d    = dbg_we;
               addr_d  = dbg_addr;
               wdata_d = dbg_wdata;
               strb_d  = dbg_strb;
               state_d = ST_ISSUE;
            end else if (data_gnt) begin
               owner_d = OWN_DATA;
               we_d    = data_we;
               addr_d  = data_addr;
               wdata_d = data_wdata;
               strb_d  = data_strb;
               state_d = ST_ISSUE;
            end else if (instr_gnt) begin
               owner_d = OWN_INSTR;
               we_d    = 1'b0;
               addr_d  = instr_addr;
               wdata_d = '0;
               strb_d  = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d = ST_IDLE;
            end else begin
               lat_d   = LAT_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               case (owner_q)
                  OWN_DBG:   dbg_rdata_d   = mem_rdata;
                  OWN_DATA:  data_rdata_d  = mem_rdata;
                  OWN_INSTR: instr_rdata_d = mem_rdata;
                  default:   ;
               endcase
               state_d = ST_RESP;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // starvation counter: counts ungranted instr request cycles, saturating
   always_comb begin
      starve_d = starve_q;
      if (!instr_req || instr_gnt) begin
         starve_d = '0;
      end else if (starve_q != STV_MAX) begin
         starve_d = starve_q + STV_W'(1);
      end
   end

   // memory strobe and read responses, driven only in ISSUE / RESP
   always_comb begin
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_strb     = '0;
      dbg_rvalid   = 1'b0;
      data_rvalid  = 1'b0;
      instr_rvalid = 1'b0;
      if (state_q == ST_ISSUE) begin
         mem_en   = 1'b1;
         mem_we   = we_q;
         mem_addr = addr_q;
         if (we_q) begin
            mem_wdata = wdata_q;
            mem_strb  = strb_q;
         end
      end
      if (state_q == ST_RESP) begin
         case (owner_q)
            OWN_DBG:   dbg_rvalid   = 1'b1;
            OWN_DATA:  data_rvalid  = 1'b1;
            OWN_INSTR: instr_rvalid = 1'b1;
            default:   ;
         endcase
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign dbg_rdata   = dbg_rdata_q;
   assign data_rdata  = data_rdata_q;
   assign instr_rdata = instr_rdata_q;

   // control and response state; reset drops any in-flight read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         owner_q       <= OWN_DBG;
         we_q          <= 1'b0;
         lat_q         <= '0;
         starve_q      <= '0;
         dbg_rdata_q   <= '0;
         data_rdata_q  <= '0;
         instr_rdata_q <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         lat_q         <= lat_d;
         starve_q      <= starve_d;
         dbg_rdata_q   <= dbg_rdata_d;
         data_rdata_q  <= data_rdata_d;
         instr_rdata_q <= instr_rdata_d;
      end
   end

   // registered command payload; only observed while ISSUE is active
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run against
// a transaction-level reference model (grant cycle -> fixed event schedule).
module tb_mem_arbiter;

   localparam int MEM_LAT      = 3;
   localparam int STARVE_LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dbg_req, dbg_we, data_req, data_we, instr_req;
   logic [31:0] dbg_addr, dbg_wdata, data_addr, data_wdata, instr_addr;
   logic [3:0]  dbg_strb, data_strb;
   logic        dbg_gnt, data_gnt, instr_gnt;
   logic        dbg_rvalid, data_rvalid, instr_rvalid;
   logic [31:0] dbg_rdata, data_rdata, instr_rdata;
   logic        mem_en, mem_we, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_strb;

   mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_strb(dbg_strb), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_strb(data_strb), .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
      .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
      .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_strb(mem_strb), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // memory environment: word array plus scheduled read returns
   logic [31:0] mem_arr [256];
   logic [31:0] rd_sched [16];
   bit          rd_sched_v [16];

   // reference model: current transaction and its fixed schedule
   int          free_at;
   bit          t_vld, t_rd;
   int          t_gnt, t_own;
   logic [31:0] t_addr, t_wdata, t_data;
   logic [3:0]  t_strb;
   logic [31:0] exp_rd [3];
   int          starve;

   // expectations for the current cycle
   logic [2:0]  e_gnt;
   logic        e_busy;
   logic [69:0] e_mem;
   logic [2:0]  e_rv;

   task automatic reset_model();
      free_at = cyc;
      t_vld   = 1'b0;
      starve  = 0;
      for (int p = 0; p < 3; p++) exp_rd[p] = '0;
      for (int s = 0; s < 16; s++) rd_sched_v[s] = 1'b0;
   endtask

   // drive memory return for this cycle and compute expected outputs
   task automatic eval();
      logic boost;
      mem_rdata = rd_sched_v[cyc % 16] ? rd_sched[cyc % 16] : $urandom;
      rd_sched_v[cyc % 16] = 1'b0;
      if (t_vld && t_rd && cyc == t_gnt + 2 + MEM_LAT) exp_rd[t_own] = t_data;
      e_busy = (cyc < free_at);
      boost  = (starve == STARVE_LIMIT) && instr_req;
      e_gnt  = 3'b000;
      if (!e_busy) begin
         if (boost)          e_gnt = 3'b100;
         else if (dbg_req)   e_gnt = 3'b001;
         else if (data_req)  e_gnt = 3'b010;
         else if (instr_req) e_gnt = 3'b100;
      end
      e_mem = '0;
      if (t_vld && cyc == t_gnt + 1)
         e_mem = {1'b1, ~t_rd, t_addr, t_rd ? 32'h0 : t_wdata, t_rd ? 4'h0 : t_strb};
      e_rv = 3'b000;
      if (t_vld && t_rd && cyc == t_gnt + 2 + MEM_LAT) e_rv[t_own] = 1'b1;
      #2;
   endtask

   // apply memory side effects, advance the model, move to the next cycle
   task automatic commit();
      int idx;
      if (mem_en === 1'b1) begin
         idx = int'(mem_addr[9:2]);
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_strb[b]) mem_arr[idx][8*b +: 8] = mem_wdata[8*b +: 8];
         end else begin
            rd_sched[(cyc + MEM_LAT) % 16]   = mem_arr[idx];
            rd_sched_v[(cyc + MEM_LAT) % 16] = 1'b1;
         end
      end
      if (e_gnt != 3'b000) begin
         t_vld = 1'b1;
         t_gnt = cyc;
         if (e_gnt[0]) begin
            t_own = 0; t_rd = !dbg_we; t_addr = dbg_addr; t_wdata = dbg_wdata; t_strb = dbg_strb;
         end else if (e_gnt[1]) begin
            t_own = 1; t_rd = !data_we; t_addr = data_addr; t_wdata = data_wdata; t_strb = data_strb;
         end else begin
            t_own = 2; t_rd = 1'b1; t_addr = instr_addr; t_wdata = '0; t_strb = '0;
         end
         t_data  = mem_arr[t_addr[9:2]];
         free_at = cyc + (t_rd ? 3 + MEM_LAT : 2);
      end
      if (!instr_req || e_gnt[2]) starve = 0;
      else if (starve < STARVE_LIMIT) starve++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      for (int g = 0; g < 64 && cyc < free_at; g++) begin
         eval();
         commit();
      end
   endtask

   task automatic test_reset();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, mem_strb} !== 70'h0) begin
         n_bad++; $display("FAIL reset_mem: got %h want 0", {mem_en, mem_we, mem_addr, mem_wdata, mem_strb});
      end
      n_cmp++;
      if ({instr_rvalid, data_rvalid, dbg_rvalid} !== 3'b000) begin
         n_bad++; $display("FAIL reset_rvalid: got %b want 000", {instr_rvalid, data_rvalid, dbg_rvalid});
      end
      n_cmp++;
      if ({instr_rdata, data_rdata, dbg_rdata} !== 96'h0) begin
         n_bad++; $display("FAIL reset_rdata: got %h want 0", {instr_rdata, data_rdata, dbg_rdata});
      end
      rst_n = 1'b1;
      cyc   = 0;
      reset_model();
      eval();
      n_cmp++;
      if ({instr_gnt, data_gnt, dbg_gnt, busy} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_idle: got %b want 0000", {instr_gnt, data_gnt, dbg_gnt, busy});
      end
      commit();
   endtask

   task automatic test_lone_instr_read();
      mem_arr[4] = 32'hDEADBEEF;
      instr_req  = 1'b1;
      instr_addr = 32'h10;
      eval();
      n_cmp++;
      if ({instr_gnt, data_gnt, dbg_gnt} !== 3'b100) begin
         n_bad++; $display("FAIL lone_gnt: got %b want 100", {instr_gnt, data_gnt, dbg_gnt});
      end
      commit();
      instr_req = 1'b0;
      for (int k = 1; k <= MEM_LAT + 3; k++) begin
         eval();
         n_cmp++;
         if (busy !== (k <= MEM_LAT + 2)) begin n_bad++; $display("FAIL lone_busy T+%0d: got %b", k, busy); end
         n_cmp++;
         if (mem_en !== (k == 1)) begin n_bad++; $display("FAIL lone_mem_en T+%0d: got %b", k, mem_en); end
         if (k == 1) begin
            n_cmp++;
            if ({mem_we, mem_addr, mem_wdata, mem_strb} !== {1'b0, 32'h10, 32'h0, 4'h0}) begin
               n_bad++; $display("FAIL lone_cmd: got %h want %h", {mem_we, mem_addr, mem_wdata, mem_strb},
                                 {1'b0, 32'h10, 32'h0, 4'h0});
            end
         end
         n_cmp++;
         if (instr_rvalid !== (k == MEM_LAT + 2)) begin
            n_bad++; $display("FAIL lone_rvalid T+%0d: got %b", k, instr_rvalid);
         end
         if (k == MEM_LAT + 2) begin
            n_cmp++;
            if (instr_rdata !== 32'hDEADBEEF) begin
               n_bad++; $display("FAIL lone_rdata: got %h want deadbeef", instr_rdata);
            end
         end
         commit();
      end
   endtask

   task automatic test_data_write();
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20;
      data_wdata = 32'h12345678; data_strb = 4'b0011;
      eval();
      n_cmp++;
      if ({instr_gnt, data_gnt, dbg_gnt} !== 3'b010) begin
         n_bad++; $display("FAIL wr_gnt: got %b want 010", {instr_gnt, data_gnt, dbg_gnt});
      end
      commit();
      data_req = 1'b0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
      eval();
      n_cmp++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, mem_strb} !== {1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011}) begin
         n_bad++; $display("FAIL wr_cmd: got %h", {mem_en, mem_we, mem_addr, mem_wdata, mem_strb});
      end
      n_cmp++;
      if ({instr_gnt, data_gnt, dbg_gnt, data_rvalid} !== 4'b0000) begin
         n_bad++; $display("FAIL wr_busy_gnt: got %b want 0000", {instr_gnt, data_gnt, dbg_gnt, data_rvalid});
      end
      commit();
      eval();
      n_cmp++;
      if ({instr_gnt, data_gnt, dbg_gnt, mem_en, data_rvalid} !== 5'b00100) begin
         n_bad++; $display("FAIL wr_next_gnt: got %b want 00100", {instr_gnt, data_gnt, dbg_gnt, mem_en, data_rvalid});
      end
      commit();
      dbg_req = 1'b0;
      drain();
   endtask

   task automatic test_starvation();
      logic [2:0] want;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wdata = 32'h11112222; dbg_strb = 4'hF;
      data_req = 1'b1; data_we = 1'b1; data_addr = 32'h104; data_wdata = 32'h33334444; data_strb = 4'hF;
      instr_req = 1'b1; instr_addr = 32'h108;
      for (int j = 0; j <= STARVE_LIMIT; j++) begin
         eval();
         if (j == STARVE_LIMIT) want = 3'b100;
         else if (j % 2 == 0)   want = 3'b001;
         else                   want = 3'b000;
         n_cmp++;
         if ({instr_gnt, data_gnt, dbg_gnt} !== want) begin
            n_bad++; $display("FAIL starve_gnt j=%0d: got %b want %b", j, {instr_gnt, data_gnt, dbg_gnt}, want);
         end
         commit();
      end
      dbg_req = 1'b0; data_req = 1'b0; instr_req = 1'b0;
      n_cmp++;
      if (u_dut.starve_q !== '0) begin n_bad++; $display("FAIL starve_clear: got %0d want 0", u_dut.starve_q); end
      drain();
   endtask

   task automatic test_data_read_lat();
      mem_arr[16] = 32'hA5A55A5A;
      data_req = 1'b1; data_we = 1'b0; data_addr = 32'h40;
      eval();
      n_cmp++;
      if ({instr_gnt, data_gnt, dbg_gnt} !== 3'b010) begin
         n_bad++; $display("FAIL rd_gnt: got %b want 010", {instr_gnt, data_gnt, dbg_gnt});
      end
      commit();
      data_req = 1'b0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h80; dbg_wdata = 32'h0; dbg_strb = 4'h1;
      for (int k = 1; k <= MEM_LAT + 2; k++) begin
         eval();
         n_cmp++;
         if ({instr_gnt, data_gnt, dbg_gnt} !== 3'b000) begin
            n_bad++; $display("FAIL rd_nognt T+%0d: got %b", k, {instr_gnt, data_gnt, dbg_gnt});
         end
         n_cmp++;
         if ({mem_en, data_rvalid} !== {k == 1, k == MEM_LAT + 2}) begin
            n_bad++; $display("FAIL rd_timing T+%0d: got %b", k, {mem_en, data_rvalid});
         end
         if (k == MEM_LAT + 2) begin
            n_cmp++;
            if (data_rdata !== 32'hA5A55A5A) begin n_bad++; $display("FAIL rd_data: got %h want a5a55a5a", data_rdata); end
         end
         commit();
      end
      eval();
      n_cmp++;
      if ({instr_gnt, data_gnt, dbg_gnt} !== 3'b001) begin
         n_bad++; $display("FAIL rd_next_gnt: got %b want 001", {instr_gnt, data_gnt, dbg_gnt});
      end
      commit();
      dbg_req = 1'b0;
      drain();
      eval();
      n_cmp++;
      if (data_rdata !== 32'hA5A55A5A) begin n_bad++; $display("FAIL rd_hold: got %h want a5a55a5a", data_rdata); end
      commit();
   endtask

   task automatic test_reset_in_wait();
      mem_arr[12] = 32'h0BADF00D;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h30;
      eval();
      n_cmp++;
      if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL rstw_gnt: got %b want 1", dbg_gnt); end
      commit();
      dbg_req = 1'b0; instr_req = 1'b1; instr_addr = 32'h10;
      eval();
      commit();
      eval();
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, mem_en, mem_we, mem_addr, mem_wdata, mem_strb} !== 71'h0) begin
         n_bad++; $display("FAIL rstw_mem: got %h want 0", {busy, mem_en, mem_we, mem_addr, mem_wdata, mem_strb});
      end
      n_cmp++;
      if ({instr_rvalid, data_rvalid, dbg_rvalid, instr_rdata, data_rdata, dbg_rdata} !== 99'h0) begin
         n_bad++; $display("FAIL rstw_resp: got %h want 0", {instr_rvalid, data_rvalid, dbg_rvalid, dbg_rdata});
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc += 2;
      reset_model();
      eval();
      n_cmp++;
      if ({instr_gnt, data_gnt, dbg_gnt} !== 3'b100) begin
         n_bad++; $display("FAIL rstw_pending: got %b want 100", {instr_gnt, data_gnt, dbg_gnt});
      end
      commit();
      instr_req = 1'b0;
      for (int k = 1; k <= MEM_LAT + 3; k++) begin
         eval();
         n_cmp++;
         if ({dbg_rvalid, instr_rvalid} !== {1'b0, k == MEM_LAT + 2}) begin
            n_bad++; $display("FAIL rstw_rvalid T+%0d: got %b", k, {dbg_rvalid, instr_rvalid});
         end
         if (k == MEM_LAT + 2) begin
            n_cmp++;
            if (instr_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rstw_rdata: got %h", instr_rdata); end
         end
         commit();
      end
   endtask

   task automatic test_withdraw();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h30;
      eval();
      n_cmp++;
      if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL wd_gnt: got %b want 1", dbg_gnt); end
      commit();
      dbg_req = 1'b0; instr_req = 1'b1; instr_addr = 32'h50;
      eval();
      n_cmp++;
      if ({instr_gnt, mem_en, mem_addr} !== {1'b0, 1'b1, 32'h30}) begin
         n_bad++; $display("FAIL wd_issue: got %h", {instr_gnt, mem_en, mem_addr});
      end
      commit();
      instr_req = 1'b0;
      for (int k = 2; k <= MEM_LAT + 3; k++) begin
         eval();
         n_cmp++;
         if ({instr_gnt, mem_en} !== 2'b00) begin
            n_bad++; $display("FAIL wd_quiet T+%0d: got %b want 00", k, {instr_gnt, mem_en});
         end
         commit();
      end
      n_cmp++;
      if (u_dut.starve_q !== '0) begin n_bad++; $display("FAIL wd_starve: got %0d want 0", u_dut.starve_q); end
   endtask

   task automatic test_random();
      logic [2:0] last_gnt;
      last_gnt = 3'b000;
      for (int i = 0; i < 800; i++) begin
         if (!dbg_req || last_gnt[0]) begin
            dbg_req = ($urandom_range(0, 3) == 0); dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = $urandom; dbg_wdata = $urandom; dbg_strb = 4'($urandom);
         end else if ($urandom_range(0, 11) == 0) dbg_req = 1'b0;
         if (!data_req || last_gnt[1]) begin
            data_req = ($urandom_range(0, 1) == 0); data_we = 1'($urandom_range(0, 1));
            data_addr = $urandom; data_wdata = $urandom; data_strb = 4'($urandom);
         end else if ($urandom_range(0, 11) == 0) data_req = 1'b0;
         if (!instr_req || last_gnt[2]) begin
            instr_req = ($urandom_range(0, 1) == 0); instr_addr = $urandom;
         end else if ($urandom_range(0, 19) == 0) instr_req = 1'b0;
         eval();
         n_cmp++;
         if ({instr_gnt, data_gnt, dbg_gnt} !== e_gnt) begin
            n_bad++; $display("FAIL rnd_gnt c%0d: got %b want %b", cyc, {instr_gnt, data_gnt, dbg_gnt}, e_gnt);
         end
         n_cmp++;
         if (busy !== e_busy) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, e_busy); end
         n_cmp++;
         if ({mem_en, mem_we, mem_addr, mem_wdata, mem_strb} !== e_mem) begin
            n_bad++; $display("FAIL rnd_mem c%0d: got %h want %h", cyc,
                              {mem_en, mem_we, mem_addr, mem_wdata, mem_strb}, e_mem);
         end
         n_cmp++;
         if ({instr_rvalid, data_rvalid, dbg_rvalid} !== e_rv) begin
            n_bad++; $display("FAIL rnd_rvalid c%0d: got %b want %b", cyc, {instr_rvalid, data_rvalid, dbg_rvalid}, e_rv);
         end
         n_cmp++;
         if ({instr_rdata, data_rdata, dbg_rdata} !== {exp_rd[2], exp_rd[1], exp_rd[0]}) begin
            n_bad++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, {instr_rdata, data_rdata, dbg_rdata},
                              {exp_rd[2], exp_rd[1], exp_rd[0]});
         end
         last_gnt = e_gnt;
         commit();
      end
      dbg_req = 1'b0; data_req = 1'b0; instr_req = 1'b0;
      drain();
   endtask

   initial begin
      rst_n = 1'b0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_strb = '0;
      data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_strb = '0;
      instr_req = 1'b0; instr_addr = '0;
      mem_rdata = '0;
      for (int a = 0; a < 256; a++) mem_arr[a] = $urandom;
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_lone_instr_read();
      test_data_write();
      test_starvation();
      test_data_read_lat();
      test_reset_in_wait();
      test_withdraw();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
